// File: rtl/Pipe_Buf_Reg_PKG.sv
// ============================================================================
// Pipe_Buf_Reg_PKG : shared pipeline types and constants
// Rev 1.0 : data-memory arbiter state encoding and debug access size
// ============================================================================
`default_nettype none

package Pipe_Buf_Reg_PKG;

   typedef enum logic [1:0] {
      ARB  = 2'd0,
      DBG  = 2'd1,
      COOL = 2'd2
   } dmem_arb_state_e;

   localparam logic [2:0] DBG_FUNC3 = 3'b010;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_starve_cnt.sv
// ============================================================================
// dmem_arb_starve_cnt : saturating count of CPU-busy cycles a debug request waited
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module dmem_arb_starve_cnt #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc_i,
   input  logic clr_i,
   output logic max_o
);

   localparam logic [3:0] MAX_C = 4'(STARVE_MAX);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 4'd0;
      end else if (inc_i && (cnt_q != MAX_C)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign max_o = (cnt_q == MAX_C);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : shares the data memory between the MEM stage and a debug port
// Rev 1.0 : CPU priority with bounded-wait forced debug grant
// ============================================================================
`default_nettype none

module dmem_arbiter
   import Pipe_Buf_Reg_PKG::*;
#(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_rd,
   input  logic                  cpu_wr,
   input  logic [DM_ADDRESS-1:0] cpu_addr,
   input  logic [DATA_W-1:0]     cpu_wdata,
   input  logic [2:0]            cpu_func3,
   output logic [DATA_W-1:0]     cpu_rdata,
   output logic                  cpu_stall,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [DM_ADDRESS-1:0] dbg_addr,
   input  logic [DATA_W-1:0]     dbg_wdata,
   output logic                  dbg_gnt,
   output logic                  dbg_rvalid,
   output logic [DATA_W-1:0]     dbg_rdata,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [2:0]            mem_func3,
   input  logic [DATA_W-1:0]     mem_rdata
);

   dmem_arb_state_e         state_q;
   dmem_arb_state_e         state_d;
   logic                    busy;
   logic                    cnt_inc;
   logic                    cnt_clr;
   logic                    cnt_max;
   logic                    rvalid_q;
   logic                    rvalid_d;
   logic [DATA_W-1:0]       rdata_q;
   logic [DATA_W-1:0]       rdata_d;

   assign busy = cpu_rd | cpu_wr;

   dmem_arb_starve_cnt #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_cnt (
      .clk   (clk),
      .reset (reset),
      .inc_i (cnt_inc),
      .clr_i (cnt_clr),
      .max_o (cnt_max)
   );

   always_comb begin
      state_d   = state_q;
      cnt_inc   = 1'b0;
      cnt_clr   = 1'b0;
      dbg_gnt   = 1'b0;
      cpu_stall = 1'b0;
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_func3 = cpu_func3;
      case (state_q)
         ARB: begin
            if (dbg_req && (!busy || cnt_max)) begin
               state_d = DBG;
            end else if (dbg_req && busy) begin
               cnt_inc = 1'b1;
            end
         end
         DBG: begin
            mem_rd    = !dbg_we;
            mem_wr    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_func3 = DBG_FUNC3;
            dbg_gnt   = 1'b1;
            cpu_stall = busy;
            cnt_clr   = 1'b1;
            state_d   = COOL;
         end
         // One CPU-owned cycle so the access released from the stall completes
         COOL: begin
            state_d = ARB;
         end
         default: begin
            state_d = ARB;
         end
      endcase
   end

   always_comb begin
      rvalid_d = (state_q == DBG) && !dbg_we;
      rdata_d  = rvalid_d ? mem_rdata : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ARB;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign cpu_rdata  = mem_rdata;
   assign dbg_rvalid = rvalid_q;
   assign dbg_rdata  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : directed vectors for dmem_arbiter with a word memory model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_rd, cpu_wr;
   logic [8:0]  cpu_addr;
   logic [31:0] cpu_wdata;
   logic [2:0]  cpu_func3;
   logic        dbg_req, dbg_we;
   logic [8:0]  dbg_addr;
   logic [31:0] dbg_wdata;

   logic [31:0] cpu_rdata0, dbg_rdata0, mem_wdata0, mem_rdata0;
   logic        cpu_stall0, dbg_gnt0, dbg_rvalid0, mem_rd0, mem_wr0;
   logic [8:0]  mem_addr0;
   logic [2:0]  mem_func30;

   logic [31:0] cpu_rdata1, dbg_rdata1, mem_wdata1;
   logic        cpu_stall1, dbg_gnt1, dbg_rvalid1, mem_rd1, mem_wr1;
   logic [8:0]  mem_addr1;
   logic [2:0]  mem_func31;

   logic [31:0] mem [0:511];
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .STARVE_MAX(4)) dut0 (
      .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_func3(cpu_func3), .cpu_rdata(cpu_rdata0), .cpu_stall(cpu_stall0),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt0), .dbg_rvalid(dbg_rvalid0), .dbg_rdata(dbg_rdata0),
      .mem_rd(mem_rd0), .mem_wr(mem_wr0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .mem_func3(mem_func30), .mem_rdata(mem_rdata0)
   );

   dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .STARVE_MAX(0)) dut1 (
      .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_func3(cpu_func3), .cpu_rdata(cpu_rdata1), .cpu_stall(cpu_stall1),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt1), .dbg_rvalid(dbg_rvalid1), .dbg_rdata(dbg_rdata1),
      .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_func3(mem_func31), .mem_rdata(32'h0)
   );

   // Word-wide data memory model: combinational read, write on the clock edge
   assign mem_rdata0 = mem[mem_addr0];
   always @(posedge clk) begin
      if (mem_wr0) mem[mem_addr0] <= mem_wdata0;
   end

   always @(negedge clk) begin
      if (cpu_rd && cpu_wr) begin
         $display("FAIL cpu_rd_wr_both: got rd=%0b wr=%0b required not both", cpu_rd, cpu_wr);
         n_fail++;
      end
   end

   typedef struct {
      logic        crd, cwr;
      logic [8:0]  caddr;
      logic [31:0] cwd;
      logic [2:0]  cf3;
      logic        dreq, dwe;
      logic [8:0]  daddr;
      logic [31:0] dwd;
      logic        gnt, stall, rv, mrd, mwr;
      logic [8:0]  maddr;
      logic [2:0]  f3;
      logic        ck_wd;
      logic [31:0] e_wd;
      logic        ck_crd;
      logic [31:0] e_crd;
      logic        ck_drd;
      logic [31:0] e_drd;
   } vec_t;

   vec_t vt [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h required %0h", name, act, exp);
         n_fail++;
      end
   endtask

   task automatic drive(input logic crd, input logic cwr, input logic [8:0] caddr,
                        input logic [31:0] cwd, input logic [2:0] cf3, input logic dreq,
                        input logic dwe, input logic [8:0] daddr, input logic [31:0] dwd);
      @(negedge clk);
      cpu_rd = crd; cpu_wr = cwr; cpu_addr = caddr; cpu_wdata = cwd; cpu_func3 = cf3;
      dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 32'h0;
      mem[9'h020] = 32'h1234_5678;

      //        crd cwr caddr   cwd           cf3     dreq dwe daddr   dwd           gnt st rv mrd mwr maddr  f3      ckwd ewd           ckcrd ecrd          ckdrd edrd
      vt[0] = '{0, 0, 9'h000, 32'h0,        3'b000, 0, 0, 9'h000, 32'h0,        0, 0, 0, 0, 0, 9'h000, 3'b000, 0, 32'h0,        0, 32'h0,        1, 32'h0};
      vt[1] = '{0, 0, 9'h000, 32'h0,        3'b000, 1, 1, 9'h010, 32'hDEADBEEF, 0, 0, 0, 0, 0, 9'h000, 3'b000, 0, 32'h0,        0, 32'h0,        0, 32'h0};
      vt[2] = '{0, 0, 9'h000, 32'h0,        3'b000, 1, 1, 9'h010, 32'hDEADBEEF, 1, 0, 0, 0, 1, 9'h010, 3'b010, 1, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0};
      vt[3] = '{1, 0, 9'h010, 32'h0,        3'b010, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 0, 9'h010, 3'b010, 0, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0};
      vt[4] = '{0, 0, 9'h000, 32'h0,        3'b000, 1, 0, 9'h020, 32'h0,        0, 0, 0, 0, 0, 9'h000, 3'b000, 0, 32'h0,        0, 32'h0,        0, 32'h0};
      vt[5] = '{0, 0, 9'h000, 32'h0,        3'b000, 1, 0, 9'h020, 32'h0,        1, 0, 0, 1, 0, 9'h020, 3'b010, 0, 32'h0,        0, 32'h0,        0, 32'h0};
      vt[6] = '{0, 0, 9'h000, 32'h0,        3'b000, 0, 0, 9'h000, 32'h0,        0, 0, 1, 0, 0, 9'h000, 3'b000, 0, 32'h0,        0, 32'h0,        1, 32'h12345678};
      vt[7] = '{0, 0, 9'h000, 32'h0,        3'b000, 0, 0, 9'h000, 32'h0,        0, 0, 0, 0, 0, 9'h000, 3'b000, 0, 32'h0,        0, 32'h0,        1, 32'h12345678};
      vt[8] = '{0, 1, 9'h030, 32'hA5A5A5A5, 3'b010, 0, 0, 9'h000, 32'h0,        0, 0, 0, 0, 1, 9'h030, 3'b010, 1, 32'hA5A5A5A5, 0, 32'h0,        0, 32'h0};
      vt[9] = '{1, 0, 9'h030, 32'h0,        3'b010, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 0, 9'h030, 3'b010, 0, 32'h0,        1, 32'hA5A5A5A5, 0, 32'h0};

      reset = 1'b1;
      cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0; cpu_func3 = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(dbg_gnt0), 32'h0);
      chk("rst_rvalid", 32'(dbg_rvalid0), 32'h0);
      chk("rst_rdata", dbg_rdata0, 32'h0);
      chk("rst_stall", 32'(cpu_stall0), 32'h0);
      chk("rst_mem_rd_wr", {30'h0, mem_rd0, mem_wr0}, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         drive(vt[i].crd, vt[i].cwr, vt[i].caddr, vt[i].cwd, vt[i].cf3,
               vt[i].dreq, vt[i].dwe, vt[i].daddr, vt[i].dwd);
         chk($sformatf("v%0d_gnt", i), 32'(dbg_gnt0), 32'(vt[i].gnt));
         chk($sformatf("v%0d_stall", i), 32'(cpu_stall0), 32'(vt[i].stall));
         chk($sformatf("v%0d_rvalid", i), 32'(dbg_rvalid0), 32'(vt[i].rv));
         chk($sformatf("v%0d_mem_rd", i), 32'(mem_rd0), 32'(vt[i].mrd));
         chk($sformatf("v%0d_mem_wr", i), 32'(mem_wr0), 32'(vt[i].mwr));
         chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr0), 32'(vt[i].maddr));
         chk($sformatf("v%0d_mem_func3", i), 32'(mem_func30), 32'(vt[i].f3));
         if (vt[i].ck_wd)  chk($sformatf("v%0d_mem_wdata", i), mem_wdata0, vt[i].e_wd);
         if (vt[i].ck_crd) chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata0, vt[i].e_crd);
         if (vt[i].ck_drd) chk($sformatf("v%0d_dbg_rdata", i), dbg_rdata0, vt[i].e_drd);
      end

      // Forced grant: CPU busy every cycle; dut0 waits 4 busy cycles, dut1 none
      for (int k = 0; k < 8; k++) begin
         drive(1, 0, 9'h040, 32'h0, 3'b010, (k <= 5), 0, 9'h020, 32'h0);
         chk($sformatf("force%0d_gnt", k), 32'(dbg_gnt0), 32'(k == 5));
         chk($sformatf("force%0d_stall", k), 32'(cpu_stall0), 32'(k == 5));
         chk($sformatf("force%0d_gnt_s0", k), 32'(dbg_gnt1), 32'((k == 1) || (k == 4)));
         chk($sformatf("force%0d_stall_s0", k), 32'(cpu_stall1), 32'((k == 1) || (k == 4)));
         if (k == 5) chk("force5_mem_addr", 32'(mem_addr0), 32'h020);
         if (k == 6) begin
            chk("force6_mem_addr", 32'(mem_addr0), 32'h040);
            chk("force6_rvalid", 32'(dbg_rvalid0), 32'h1);
            chk("force6_rdata", dbg_rdata0, 32'h1234_5678);
         end
      end

      drive(0, 0, 9'h000, 32'h0, 3'b000, 0, 0, 9'h000, 32'h0);

      // Held request with CPU idle: one grant every three cycles
      for (int k = 0; k < 9; k++) begin
         drive(0, 0, 9'h000, 32'h0, 3'b000, 1, 0, 9'h020, 32'h0);
         chk($sformatf("held%0d_gnt", k), 32'(dbg_gnt0), 32'((k == 1) || (k == 4) || (k == 7)));
         chk($sformatf("held%0d_gnt_s0", k), 32'(dbg_gnt1), 32'((k == 1) || (k == 4) || (k == 7)));
         chk($sformatf("held%0d_stall", k), 32'(cpu_stall0), 32'h0);
      end
      drive(0, 0, 9'h000, 32'h0, 3'b000, 0, 0, 9'h000, 32'h0);
      drive(0, 0, 9'h000, 32'h0, 3'b000, 0, 0, 9'h000, 32'h0);

      // Reset during the DBG cycle of a read discards the read
      drive(0, 0, 9'h000, 32'h0, 3'b000, 1, 0, 9'h020, 32'h0);
      chk("rmid0_gnt", 32'(dbg_gnt0), 32'h0);
      drive(0, 0, 9'h000, 32'h0, 3'b000, 1, 0, 9'h020, 32'h0);
      reset = 1'b1;
      chk("rmid1_gnt", 32'(dbg_gnt0), 32'h1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rmid2_rvalid", 32'(dbg_rvalid0), 32'h0);
      chk("rmid2_rdata", dbg_rdata0, 32'h0);
      chk("rmid2_stall", 32'(cpu_stall0), 32'h0);
      chk("rmid2_gnt", 32'(dbg_gnt0), 32'h0);
      drive(0, 0, 9'h000, 32'h0, 3'b000, 0, 0, 9'h020, 32'h0);
      chk("rmid3_gnt_from_arb", 32'(dbg_gnt0), 32'h1);
      drive(0, 0, 9'h000, 32'h0, 3'b000, 0, 0, 9'h000, 32'h0);
      chk("rmid4_rvalid", 32'(dbg_rvalid0), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data memory between the pipeline MEM stage and a word-wide debug/loader port. CPU accesses have priority. A starvation counter guarantees the debug port a slot within a bounded number of cycles, and asserts `cpu_stall` to freeze the pipeline while the debug port holds the memory. The block sits between the EX/MEM register outputs and `datamemory`.

## Interface
Parameters:
- DM_ADDRESS, 9, data memory address width
- DATA_W, 32, data width
- STARVE_MAX, 4, CPU-busy cycles a pending debug request tolerates before forced grant; legal range 0..15

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cpu_rd  in  1  MEM-stage read request
- cpu_wr  in  1  MEM-stage write request
- cpu_addr  in  DM_ADDRESS  MEM-stage address
- cpu_wdata  in  DATA_W  MEM-stage store data
- cpu_func3  in  3  MEM-stage access size/sign
- cpu_rdata  out  DATA_W  read data to MEM/WB register
- cpu_stall  out  1  freeze pipeline this cycle
- dbg_req  in  1  debug access request, held until granted
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  DM_ADDRESS  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_gnt  out  1  access performed this cycle
- dbg_rvalid  out  1  dbg_rdata valid, one-cycle pulse
- dbg_rdata  out  DATA_W  registered debug read data
- mem_rd  out  1  to datamemory MemRead
- mem_wr  out  1  to datamemory MemWrite
- mem_addr  out  DM_ADDRESS  to datamemory address
- mem_wdata  out  DATA_W  to datamemory write data
- mem_func3  out  3  to datamemory func3
- mem_rdata  in  DATA_W  datamemory read data, combinational in the request cycle

## Operation
- The FSM has three states: ARB (reset state), DBG and COOL.
- **ARB:** the CPU owns the memory and mem_* = cpu_*. Define `busy = cpu_rd | cpu_wr`.
  - If `dbg_req && (!busy || cnt == STARVE_MAX)`, the next state is DBG.
  - Otherwise, if `dbg_req && busy`, cnt increments, saturating at STARVE_MAX.
  - Otherwise cnt holds.
- **DBG:** the debug port owns the memory.
  - `mem_rd = !dbg_we`, `mem_wr = dbg_we`, `mem_addr = dbg_addr`, `mem_wdata = dbg_wdata`, `mem_func3 = 3'b010` (word access).
  - `dbg_gnt = 1`, `cpu_stall = busy`.
  - On a read, dbg_rdata captures mem_rdata at the clock edge and `dbg_rvalid = 1` in the following cycle.
  - The next state is COOL unconditionally and cnt clears.
- **COOL:** the CPU owns the memory, identical to ARB, except no debug grant is possible and cnt stays 0. The next state is ARB. This guarantees the released CPU access completes before another debug slot.
- **cpu_rdata:** equals mem_rdata in ARB and COOL, and is don't-care in DBG, where the CPU is stalled.
- **cpu_stall:** 0 outside DBG.
- **CPU rd and wr together:** both are forwarded as-is; this is illegal upstream and the bench flags it.
- **dbg_req dropped before grant:** illegal. The arbiter still completes a DBG cycle if it has already entered DBG.
- **Reset mid-operation:** state returns to ARB, cnt = 0, dbg_rvalid = 0, and any in-flight debug read is discarded.

## Timing
- **Reset values:** state ARB, cnt 0, dbg_gnt 0, dbg_rvalid 0, dbg_rdata 0, cpu_stall 0. mem_* follow cpu_* combinationally, which are 0 while the EX/MEM register is in reset.
- **Debug latency, CPU idle:** dbg_req at cycle N gives dbg_gnt at N+1 and dbg_rvalid/dbg_rdata at N+2.
- **Debug latency, CPU continuously busy:** grant at cycle N+STARVE_MAX+1, and cpu_stall is high in that same cycle only.
- **Back-to-back debug:** minimum spacing between grants is 3 cycles (DBG, COOL, ARB decision).
- **CPU path:** adds no latency; mem_* and cpu_rdata are purely combinational in ARB and COOL.
- **cnt width:** 4 bits, compared against STARVE_MAX zero-extended.

## Structure
- Shared package Pipe_Buf_Reg_PKG receives:
  - `typedef enum logic [1:0] {ARB, DBG, COOL} dmem_arb_state_e`
  - constant `DBG_FUNC3 = 3'b010`
- One natural sub-module, `dmem_arb_starve_cnt`: a saturating counter with inc, clr and max-reached output.
- The output mux and FSM stay in the top.

## Test plan
- **Reset mid-read:** dbg_req read issued, then reset asserted in the DBG cycle → next cycle dbg_rvalid 0, state ARB, cnt 0, cpu_stall 0.
- **Idle debug write:** CPU idle, dbg_req=1, dbg_we=1, addr 0x010, data 0xDEADBEEF at N → dbg_gnt at N+1 with mem_wr=1, mem_addr=0x010, mem_func3=010. A following CPU lw (func3=010) of 0x010 returns 0xDEADBEEF.
- **Idle debug read:** memory word 0x020 = 0x12345678, CPU idle, debug read at N → dbg_gnt at N+1, dbg_rvalid=1 and dbg_rdata=0x12345678 at N+2, cpu_stall never high.
- **Forced grant:** STARVE_MAX=4, cpu_rd held high every cycle, dbg read at N → dbg_gnt and cpu_stall both high exactly at N+5, COOL at N+6 with cpu_stall=0 and mem_addr=cpu_addr.
- **STARVE_MAX=0:** CPU busy every cycle, dbg_req at N → dbg_gnt at N+1 with cpu_stall=1.
- **Held request:** dbg_req held continuously with CPU idle → grants at N+1, N+4, N+7, with dbg_gnt low in the cycles between.
